// File: rtl/led_sched_pkg.sv
// Shared types and constants for the LED bank round-robin scheduler.
package led_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int LED_W_DEF = 4;
    localparam int PWM_W     = 4;

endpackage

// File: rtl/led_sched_rr_pick.sv
// Combinational round-robin pick: first valid requester after last_owner, ascending with wrap.
module led_sched_rr_pick #(
    parameter int REQ_N = 4,
    parameter int IDX_W = $clog2(REQ_N)
) (
    input  logic [REQ_N-1:0] req_valid,
    input  logic [IDX_W-1:0] last_owner,
    output logic             any,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] idx;

    // Walk from the farthest candidate down so the nearest valid one wins.
    always_comb begin
        any       = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int k = REQ_N; k >= 1; k--) begin
            idx = IDX_W'((int'(last_owner) + k) % REQ_N);
            if (req_valid[idx]) begin
                any       = 1'b1;
                grant_idx = idx;
            end
        end
    end

endmodule

// File: rtl/led_sched.sv
// Round-robin LED bank scheduler: show each granted pattern for a hold time, then blank for a gap.
// Optional LED_SCHED_PWM_EN adds a duty input that dims led in IDLE and SHOW.
module led_sched
    import led_sched_pkg::*;
#(
    parameter int REQ_N       = 4,
    parameter int LED_W       = LED_W_DEF,
    parameter int HOLD_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 2_500_000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [REQ_N-1:0]         req_valid,
    input  logic [REQ_N*LED_W-1:0]   req_pattern,
    input  logic [LED_W-1:0]         idle_pattern,
`ifdef LED_SCHED_PWM_EN
    input  logic [PWM_W-1:0]         duty,
`endif
    output logic [REQ_N-1:0]         req_ack,
    output logic                     busy,
    output logic [$clog2(REQ_N)-1:0] owner,
    output logic [LED_W-1:0]         led
);

    localparam int IDX_W   = $clog2(REQ_N);
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [LED_W-1:0] led_q;
    logic [LED_W-1:0] pat_q;
    logic [REQ_N-1:0] ack_q;
    logic             busy_q;
    logic [IDX_W-1:0] owner_q;

    logic             any;
    logic [IDX_W-1:0] grant_idx;
    logic [LED_W-1:0] grant_pat;
    logic [LED_W-1:0] on_mask;
    logic [LED_W-1:0] pat_arr [REQ_N];

    for (genvar i = 0; i < REQ_N; i++) begin : g_pat
        assign pat_arr[i] = req_pattern[i*LED_W +: LED_W];
    end
    assign grant_pat = pat_arr[grant_idx];

    led_sched_rr_pick #(.REQ_N(REQ_N), .IDX_W(IDX_W)) u_pick (
        .req_valid  (req_valid),
        .last_owner (owner_q),
        .any        (any),
        .grant_idx  (grant_idx)
    );

`ifdef LED_SCHED_PWM_EN
    logic [PWM_W-1:0] pwm_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pwm_cnt_q <= '0;
        else        pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
    end

    assign on_mask = {LED_W{pwm_cnt_q < duty}};
`else
    assign on_mask = '1;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            led_q   <= '0;
            pat_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            owner_q <= IDX_W'(REQ_N - 1);
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (any) begin
                        state_q <= SHOW;
                        cnt_q   <= HOLD_LD;
                        pat_q   <= grant_pat;
                        led_q   <= grant_pat & on_mask;
                        ack_q   <= {{(REQ_N-1){1'b0}}, 1'b1} << grant_idx;
                        busy_q  <= 1'b1;
                        owner_q <= grant_idx;
                    end else begin
                        led_q <= idle_pattern & on_mask;
                    end
                end
                SHOW: begin
                    if (cnt_q == '0) begin
                        if (GAP_CYCLES > 0) begin
                            state_q <= GAP;
                            cnt_q   <= GAP_LD;
                            led_q   <= '0;
                        end else begin
                            // Entering IDLE shows idle_pattern immediately, no blank cycle.
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            led_q   <= idle_pattern & on_mask;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        led_q <= pat_q & on_mask;
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        led_q   <= idle_pattern & on_mask;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                        led_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    led_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ack = ack_q;
    assign busy    = busy_q;
    assign owner   = owner_q;
    assign led     = led_q;

endmodule

// File: tb/tb_led_sched.sv
// Directed bench for led_sched: reset, single grant timing, round-robin order, wrap, mid-SHOW reset.
module tb_led_sched;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [15:0] req_pattern;
    logic [3:0]  idle_pattern;
    logic [3:0]  req_ack;
    logic        busy;
    logic [1:0]  owner;
    logic [3:0]  led;
`ifdef LED_SCHED_PWM_EN
    logic [3:0]  duty;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    led_sched #(
        .REQ_N(4), .LED_W(4), .HOLD_CYCLES(4), .GAP_CYCLES(2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_pattern  (req_pattern),
        .idle_pattern (idle_pattern),
`ifdef LED_SCHED_PWM_EN
        .duty         (duty),
`endif
        .req_ack      (req_ack),
        .busy         (busy),
        .owner        (owner),
        .led          (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_ack(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (req_ack != 4'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        bit ok;
        int last_t;
        reset        = 1'b0;
        req_valid    = 4'b0;
        req_pattern  = {4'h8, 4'h4, 4'h2, 4'h1};
        idle_pattern = 4'b1001;
`ifdef LED_SCHED_PWM_EN
        duty         = 4'd15;
`endif
        tick();
        tick();
        chk("rst_led", led, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_owner", owner, 2'd3);
        chk("rst_ack", req_ack, 4'b0);
        reset = 1'b1;
        chk("first_cycle_led", led, 4'h0);
        tick();
`ifndef LED_SCHED_PWM_EN
        chk("idle_led", led, 4'b1001);
`endif
        chk("idle_busy", busy, 1'b0);
        chk("idle_owner", owner, 2'd3);

`ifndef LED_SCHED_PWM_EN
        // Single request: 1 ack cycle, A for 4 cycles, 0 for 2, then idle.
        req_pattern = {4'h8, 4'h4, 4'h2, 4'hA};
        req_valid   = 4'b0001;
        tick();
        chk("single_ack", req_ack, 4'b0001);
        chk("single_owner", owner, 2'd0);
        chk("single_busy", busy, 1'b1);
        req_valid = 4'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            chk($sformatf("single_show%0d", i), led, 4'hA);
        end
        chk("single_ack_once", req_ack, 4'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("single_gap%0d", i), led, 4'h0);
            chk($sformatf("single_gap_busy%0d", i), busy, 1'b1);
        end
        tick();
        chk("single_back_idle", led, 4'b1001);
        chk("single_idle_busy", busy, 1'b0);

        // All four held: grants 0,1,2,3,0 seven cycles apart.
        reset = 1'b0;
        #2;
        reset = 1'b1;
        req_pattern = {4'h8, 4'h4, 4'h2, 4'h1};
        req_valid   = 4'b1111;
        last_t      = 0;
        for (int g = 0; g < 5; g++) begin
            wait_ack($sformatf("rr%0d", g), ok);
            if (ok) begin
                chk($sformatf("rr_ack%0d", g), req_ack, 32'd1 << (g % 4));
                chk($sformatf("rr_led%0d", g), led, 32'd1 << (g % 4));
                if (g > 0) chk($sformatf("rr_space%0d", g), cyc - last_t, 7);
                last_t = cyc;
            end
        end

        // Owner 1 served, then 0011 pending: wrap from 2 to 0.
        req_valid = 4'b0010;
        wait_ack("own1", ok);
        if (ok) chk("own1_owner", owner, 2'd1);
        req_valid = 4'b0011;
        wait_ack("wrap", ok);
        if (ok) begin
            chk("wrap_ack", req_ack, 4'b0001);
            chk("wrap_owner", owner, 2'd0);
        end

        // Reset on the second SHOW cycle.
        req_valid = 4'b0100;
        wait_ack("mid", ok);
        if (ok) chk("mid_ack", req_ack, 4'b0100);
        req_valid = 4'b0;
        tick();
        chk("mid_show2_led", led, 4'h4);
        chk("mid_show2_ack", req_ack, 4'b0);
        reset = 1'b0;
        #1;
        chk("mid_rst_led", led, 4'h0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_owner", owner, 2'd3);
        chk("mid_rst_ack", req_ack, 4'b0);
        #1;
        reset = 1'b1;
        tick();
        tick();
        chk("mid_after_ack", req_ack, 4'b0);
        chk("mid_after_led", led, 4'b1001);
`else
        // PWM: 4 of 16 idle cycles lit at duty=4, none at duty=0, SHOW dark at duty=0.
        begin
            int lit;
            idle_pattern = 4'hF;
            duty         = 4'd4;
            tick();
            lit = 0;
            for (int i = 0; i < 16; i++) begin
                tick();
                if (led == 4'hF) lit++;
                else chk($sformatf("pwm_partial%0d", i), led, 4'h0);
            end
            chk("pwm_duty4_lit", lit, 4);
            duty = 4'd0;
            tick();
            lit = 0;
            for (int i = 0; i < 16; i++) begin
                tick();
                if (led != 4'h0) lit++;
            end
            chk("pwm_duty0_lit", lit, 0);
            req_pattern = {4'h8, 4'h4, 4'h2, 4'hF};
            req_valid   = 4'b0001;
            tick();
            chk("pwm_ack", req_ack, 4'b0001);
            req_valid = 4'b0;
            lit = 0;
            for (int i = 0; i < 4; i++) begin
                if (i > 0) tick();
                if (led != 4'h0) lit++;
            end
            chk("pwm_show_dark", lit, 0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
